// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared definitions for the flip-flop scan chain controller:
//               chain geometry helpers, fixed bit positions and FSM states.
//               Chain layout (bit 0 leaves the chain first):
//                 [0]                 soft-reset bit
//                 [W:1]               writable configuration field
//                 [L-1:W+1]           read-only status field
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    // Fixed positions at the serial-out end of the chain
    localparam int SOFT_RST_BIT = 0;
    localparam int WR_LSB       = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } scan_state_e;

    // Total chain length: soft-reset bit + write field + read field
    function automatic int scan_len(input int w, input int r);
        return 1 + w + r;
    endfunction

    // First bit of the read-only field for a write field of width w
    function automatic int rd_lsb(input int w);
        return w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_len_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_len_counter
// Description : Saturating shift counter for a scan chain. Counts up to
//               LEN+1 and holds there, so any overshift stays distinguishable
//               from an exact-length shift.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (count -> 0)
//               i_clr    - clear count to 0 (wins over i_inc)
//               i_inc    - increment (saturates at LEN+1)
//               o_eq_len - count equals LEN exactly
// Revision    : 1.0 - initial release
// ============================================================================
module scan_len_counter #(
    parameter int CW  = 5,
    parameter int LEN = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_eq_len
);

    localparam logic [CW-1:0] c_len = CW'(LEN);
    localparam logic [CW-1:0] c_sat = CW'(LEN + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != c_sat)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_eq_len = (r_cnt == c_len);

endmodule
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scan_chain_ctrl
// Description : Single-clock flip-flop scan chain for configuration write and
//               status readback, with length-checked commits.
// Ports       : clock            - system clock, rising edge
//               reset            - synchronous active-high reset
//               scan_shift       - shift chain one bit toward bit 0
//               scan_data_in     - serial in, enters at chain MSB
//               scan_data_out    - serial out, chain bit 0 (registered)
//               scan_capture     - parallel load {chip_in, chip_out, soft}
//               scan_update      - request commit of the write field
//               chip_in          - status bits to capture
//               chip_out         - committed configuration
//               chip_soft_reset  - committed soft-reset bit
//               scan_busy        - high while in COMMIT
//               scan_update_done - one-cycle pulse after a successful commit
//               scan_len_err     - sticky wrong-shift-count flag
// Revision    : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl
    import scan_pkg::*;
#(
    parameter int                 W_WIDTH   = 32,
    parameter int                 R_WIDTH   = 32,
    parameter logic [W_WIDTH-1:0] RESET_VAL = {W_WIDTH{1'b0}}
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               scan_shift,
    input  logic               scan_data_in,
    output logic               scan_data_out,
    input  logic               scan_capture,
    input  logic               scan_update,
    input  logic [R_WIDTH-1:0] chip_in,
    output logic [W_WIDTH-1:0] chip_out,
    output logic               chip_soft_reset,
    output logic               scan_busy,
    output logic               scan_update_done,
    output logic               scan_len_err
);

    localparam int L        = scan_len(W_WIDTH, R_WIDTH);
    localparam int CW       = $clog2(L + 2);
    localparam int c_rd_lsb = rd_lsb(W_WIDTH);
    localparam int c_wr_msb = c_rd_lsb - 1;

    scan_state_e        r_state;
    scan_state_e        w_state_next;
    logic [L-1:0]       r_chain;
    logic [W_WIDTH-1:0] r_chip_out;
    logic               r_soft_reset;
    logic               r_done;
    logic               r_len_err;

    logic w_eq_len;
    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_do_shift;
    logic w_do_capture;
    logic w_do_commit;
    logic w_set_err;

    scan_len_counter #(
        .CW  (CW),
        .LEN (L)
    ) u_len_counter (
        .clk      (clock),
        .rst      (reset),
        .i_clr    (w_cnt_clr),
        .i_inc    (w_cnt_inc),
        .o_eq_len (w_eq_len)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobe priority is capture > update > shift. COMMIT ignores every
    // strobe so the committed value always matches the checked chain.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_do_shift   = 1'b0;
        w_do_capture = 1'b0;
        w_do_commit  = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE, SHIFT: begin
                if (scan_capture) begin
                    w_do_capture = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = IDLE;
                end else if (scan_update) begin
                    // Only an exact-length shift sequence may commit; IDLE
                    // always has a zero count, so it always errors here.
                    if ((r_state == SHIFT) && w_eq_len) begin
                        w_state_next = COMMIT;
                    end else begin
                        w_set_err    = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = IDLE;
                    end
                end else if (scan_shift) begin
                    w_do_shift   = 1'b1;
                    w_cnt_inc    = 1'b1;
                    w_state_next = SHIFT;
                end
            end
            COMMIT: begin
                w_do_commit  = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_chain      <= '0;
            r_chip_out   <= RESET_VAL;
            r_soft_reset <= 1'b0;
            r_done       <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_done <= w_do_commit;

            if (w_do_capture) begin
                r_chain[L-1:c_rd_lsb]     <= chip_in;
                r_chain[c_wr_msb:WR_LSB]  <= r_chip_out;
                r_chain[SOFT_RST_BIT]     <= r_soft_reset;
            end else if (w_do_shift) begin
                r_chain <= {scan_data_in, r_chain[L-1:1]};
            end

            // A committed soft-reset bit forces the configuration back to
            // its reset value instead of loading the write field.
            if (w_do_commit) begin
                r_soft_reset <= r_chain[SOFT_RST_BIT];
                r_chip_out   <= r_chain[SOFT_RST_BIT] ? RESET_VAL
                                                      : r_chain[c_wr_msb:WR_LSB];
                r_len_err    <= 1'b0;
            end else if (w_set_err) begin
                r_len_err    <= 1'b1;
            end
        end
    end

    assign scan_data_out    = r_chain[SOFT_RST_BIT];
    assign chip_out         = r_chip_out;
    assign chip_soft_reset  = r_soft_reset;
    assign scan_busy        = (r_state == COMMIT);
    assign scan_update_done = r_done;
    assign scan_len_err     = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_chain_ctrl
// Description : Self-checking bench for scan_chain_ctrl (W=8, R=8, L=17).
//               A queue-based reference model tracks the chain as a list of
//               bits in exit order plus a shift count since the last
//               capture/update; every cycle all outputs are compared with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;

    localparam int         W  = 8;
    localparam int         R  = 8;
    localparam int         L  = 1 + W + R;
    localparam logic [7:0] RV = 8'h96;

    logic         clock = 1'b0;
    logic         reset;
    logic         scan_shift;
    logic         scan_data_in;
    logic         scan_data_out;
    logic         scan_capture;
    logic         scan_update;
    logic [R-1:0] chip_in;
    logic [W-1:0] chip_out;
    logic         chip_soft_reset;
    logic         scan_busy;
    logic         scan_update_done;
    logic         scan_len_err;

    always #5 clock = ~clock;

    scan_chain_ctrl #(
        .W_WIDTH   (W),
        .R_WIDTH   (R),
        .RESET_VAL (RV)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .scan_shift       (scan_shift),
        .scan_data_in     (scan_data_in),
        .scan_data_out    (scan_data_out),
        .scan_capture     (scan_capture),
        .scan_update      (scan_update),
        .chip_in          (chip_in),
        .chip_out         (chip_out),
        .chip_soft_reset  (chip_soft_reset),
        .scan_busy        (scan_busy),
        .scan_update_done (scan_update_done),
        .scan_len_err     (scan_len_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state
    bit         m_q[$];      // m_q[0] is the next bit to leave the chain
    logic [7:0] m_out;
    bit         m_soft;
    bit         m_busy;
    bit         m_done;
    bit         m_err;
    int         m_cnt;       // shifts since last capture/update, capped at L+1

    task automatic model_step(input bit r, input bit cap, input bit upd,
                              input bit sh, input bit din, input logic [7:0] cin);
        m_done = 1'b0;
        if (r) begin
            m_q.delete();
            for (int i = 0; i < L; i++) m_q.push_back(1'b0);
            m_out  = RV;
            m_soft = 1'b0;
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else if (m_busy) begin
            logic [7:0] wr;
            for (int i = 0; i < 8; i++) wr[i] = m_q[1 + i];
            m_soft = m_q[0];
            m_out  = m_q[0] ? RV : wr;
            m_err  = 1'b0;
            m_cnt  = 0;
            m_done = 1'b1;
            m_busy = 1'b0;
        end else if (cap) begin
            bit nq[$];
            nq.push_back(m_soft);
            for (int i = 0; i < 8; i++) nq.push_back(m_out[i]);
            for (int i = 0; i < 8; i++) nq.push_back(cin[i]);
            m_q   = nq;
            m_cnt = 0;
        end else if (upd) begin
            if (m_cnt == L) m_busy = 1'b1;
            else            m_err  = 1'b1;
            m_cnt = 0;
        end else if (sh) begin
            void'(m_q.pop_front());
            m_q.push_back(din);
            m_cnt = (m_cnt + 1 > L + 1) ? L + 1 : m_cnt + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance DUT and model together, compare all outputs.
    task automatic step(input bit r, input bit cap, input bit upd, input bit sh, input bit din);
        reset        = r;
        scan_capture = cap;
        scan_update  = upd;
        scan_shift   = sh;
        scan_data_in = din;
        @(posedge clock);
        model_step(r, cap, upd, sh, din, chip_in);
        #1;
        chk("m_chip_out",   32'(chip_out),         32'(m_out));
        chk("m_soft_reset", 32'(chip_soft_reset),  32'(m_soft));
        chk("m_busy",       32'(scan_busy),        32'(m_busy));
        chk("m_done",       32'(scan_update_done), 32'(m_done));
        chk("m_len_err",    32'(scan_len_err),     32'(m_err));
        chk("m_data_out",   32'(scan_data_out),    32'(m_q[0]));
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, bits[i]);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         rst, cap, upd, sh, din;
        logic [7:0] cin;
        logic [7:0] e_out;
        bit         e_soft, e_busy, e_done, e_err, e_dout;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [16:0] rb;
        logic [8:0]  rb9;
        int          n;

        reset = 1'b1; scan_shift = 1'b0; scan_data_in = 1'b0;
        scan_capture = 1'b0; scan_update = 1'b0; chip_in = '0;

        // RV = 8'h96: bit0 = 0, bit1 = 1
        tbl[0] = '{1, 0, 0, 0, 0, 8'h00, RV, 0, 0, 0, 0, 0}; // reset
        tbl[1] = '{0, 0, 1, 0, 0, 8'h00, RV, 0, 0, 0, 1, 0}; // update from IDLE -> err
        tbl[2] = '{0, 1, 0, 0, 0, 8'hA5, RV, 0, 0, 0, 1, 0}; // capture, err sticky
        tbl[3] = '{0, 0, 0, 1, 1, 8'hA5, RV, 0, 0, 0, 1, 0}; // out = RV[0]
        tbl[4] = '{0, 0, 0, 1, 0, 8'hA5, RV, 0, 0, 0, 1, 1}; // out = RV[1]
        tbl[5] = '{0, 0, 1, 0, 0, 8'hA5, RV, 0, 0, 0, 1, 1}; // short update
        tbl[6] = '{0, 1, 1, 1, 1, 8'h00, RV, 0, 0, 0, 1, 0}; // capture wins
        tbl[7] = '{1, 0, 0, 0, 0, 8'h00, RV, 0, 0, 0, 0, 0}; // reset clears err
        tbl[8] = '{0, 0, 0, 0, 0, 8'h00, RV, 0, 0, 0, 0, 0}; // quiet

        for (int i = 0; i < 9; i++) begin
            chip_in = tbl[i].cin;
            step(tbl[i].rst, tbl[i].cap, tbl[i].upd, tbl[i].sh, tbl[i].din);
            chk($sformatf("tbl%0d_out", i),  32'(chip_out),         32'(tbl[i].e_out));
            chk($sformatf("tbl%0d_soft", i), 32'(chip_soft_reset),  32'(tbl[i].e_soft));
            chk($sformatf("tbl%0d_busy", i), 32'(scan_busy),        32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(scan_update_done), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d_err", i),  32'(scan_len_err),     32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_dout", i), 32'(scan_data_out),    32'(tbl[i].e_dout));
        end

        // Readback: capture then 17 serial bits = soft, chip_out, chip_in
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chip_in = 8'hA5;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < L; i++) begin
            rb[i] = scan_data_out;
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
        end
        chk("readback", 32'(rb), 32'({8'hA5, RV, 1'b0}));

        // Exact-length write of 8'h3C
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(32'({8'h00, 8'h3C, 1'b0}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("busy_after_update", 32'(scan_busy), 32'd1);
        chk("out_before_commit", 32'(chip_out), 32'(RV));
        idle();
        chk("commit_3c", 32'(chip_out), 32'h3C);
        chk("done_pulse", 32'(scan_update_done), 32'd1);
        chk("busy_cleared", 32'(scan_busy), 32'd0);
        idle();
        chk("done_one_cycle", 32'(scan_update_done), 32'd0);

        // Short shift (16) rejected, then a correct 17 recovers
        shift_bits(32'({8'h00, 8'h11, 1'b0}), L - 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("short_err", 32'(scan_len_err), 32'd1);
        chk("short_out_kept", 32'(chip_out), 32'h3C);
        chk("short_no_done", 32'(scan_update_done), 32'd0);
        shift_bits(32'({8'h00, 8'h77, 1'b0}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("recover_out", 32'(chip_out), 32'h77);
        chk("recover_err_clr", 32'(scan_len_err), 32'd0);

        // Overshift (18) rejected; capture + 17 then succeeds
        shift_bits(32'({1'b0, 8'h00, 8'h5D, 1'b0}), L + 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("over_err", 32'(scan_len_err), 32'd1);
        chk("over_out_kept", 32'(chip_out), 32'h77);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(32'({8'h00, 8'hE1, 1'b0}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("after_over_out", 32'(chip_out), 32'hE1);

        // Soft-reset commit loads RV, then reads back as soft=1, write=RV
        shift_bits(32'({8'h00, 8'hFF, 1'b1}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("soft_out", 32'(chip_out), 32'(RV));
        chk("soft_bit", 32'(chip_soft_reset), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            rb9[i] = scan_data_out;
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("soft_readback", 32'(rb9), 32'({RV, 1'b1}));

        // Coincident strobes mid-shift: capture wins, count restarts
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(32'h1F, 5);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("coinc_no_busy", 32'(scan_busy), 32'd0);
        chk("coinc_no_err", 32'(scan_len_err), 32'd0);
        idle();
        chk("coinc_no_done", 32'(scan_update_done), 32'd0);
        shift_bits(32'({8'h00, 8'h42, 1'b0}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("coinc_then_commit", 32'(chip_out), 32'h42);

        // Reset during COMMIT aborts the commit
        shift_bits(32'({8'h00, 8'h11, 1'b0}), L);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_reset_busy", 32'(scan_busy), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_out", 32'(chip_out), 32'(RV));
        chk("abort_no_done", 32'(scan_update_done), 32'd0);
        idle();
        chk("abort_no_done2", 32'(scan_update_done), 32'd0);

        // Randomized bursts checked against the model every cycle
        for (int b = 0; b < 80; b++) begin
            chip_in = 8'($urandom);
            if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            case ($urandom_range(0, 5))
                0:       n = L - 1;
                1:       n = L + 1;
                2, 3, 4: n = L;
                default: n = int'($urandom_range(0, 20));
            endcase
            for (int i = 0; i < n; i++)
                step(1'b0, ($urandom_range(0, 29) == 0), 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            step(1'b0, ($urandom_range(0, 7) == 0), 1'b1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < int'($urandom_range(1, 3)); i++)
                step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
Single-clock, flip-flop-based scan chain for chip configuration and status readback. It is the parametrised successor to the two-phase latch scan block.
- Writable fields, readable fields and a soft-reset bit are parametrised.
- Commits are length-checked: an update with the wrong shift count is rejected and flagged.
- Sits between the test-pad controller, which drives synchronous scan strobes, and the chip configuration/status nets.

Parameters:
W_WIDTH, 32, total width of writable configuration bits (chip_out)
R_WIDTH, 32, total width of read-only status bits (chip_in)
RESET_VAL, {W_WIDTH{1'b0}}, value loaded into chip_out on reset or on soft-reset commit
L (localparam), 1+W_WIDTH+R_WIDTH, chain length
CW (localparam), $clog2(L+2), shift-counter width

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
scan_shift  input  1  shift chain one bit this cycle
scan_data_in  input  1  serial data in, enters chain MSB
scan_data_out  output  1  serial data out = chain[0]
scan_capture  input  1  parallel-load chain from chip state
scan_update  input  1  request commit of chain to chip_out
chip_in  input  R_WIDTH  status bits to capture
chip_out  output  W_WIDTH  committed configuration
chip_soft_reset  output  1  committed soft-reset bit
scan_busy  output  1  high in COMMIT state
scan_update_done  output  1  one-cycle pulse on successful commit
scan_len_err  output  1  sticky length-error flag

Behaviour:
- Chain layout (bit 0 exits first):
  - bit 0 = soft-reset
  - [W_WIDTH:1] = write field
  - [L-1:W_WIDTH+1] = read field
- Reset: chain=0, cnt=0, state=IDLE, chip_out=RESET_VAL, chip_soft_reset=0, scan_update_done=0, scan_len_err=0. Reset mid-shift or mid-commit aborts; no partial commit.
- Shift: chain <= {scan_data_in, chain[L-1:1]}. cnt <= min(cnt+1, L+1); cnt saturates so overshift is detectable. scan_data_out is registered chain[0] and changes the cycle after the shift.
- Capture:
  - chain <= {chip_in, chip_out, chip_soft_reset}, sampled that cycle
  - cnt <= 0; state <= IDLE
  - Readback of chip_in is therefore one capture plus L shifts.
- Priority when strobes coincide: capture > update > shift. The lower-priority strobe is ignored that cycle.
- FSM:
  - IDLE: shift -> SHIFT. update -> IDLE with scan_len_err<=1 (cnt=0≠L).
  - SHIFT: shift stays in SHIFT. update with cnt==L -> COMMIT. update with cnt≠L -> IDLE, scan_len_err<=1, cnt<=0, chip_out unchanged.
  - COMMIT (1 cycle):
    - chip_soft_reset <= chain[0]
    - chip_out <= chain[0] ? RESET_VAL : chain[W_WIDTH:1]
    - scan_update_done <= 1 the next cycle
    - scan_len_err <= 0; cnt <= 0; -> IDLE
    - scan_busy=1; all strobes ignored, including capture.
- The chain is not altered by commit. Re-update without shifting gives cnt=0, which is an error.
- chip_out and chip_soft_reset change only at commit or reset. They are glitch-free registered outputs.
- scan_len_err is sticky until reset or the next successful commit.

Decomposition:
- Package scan_pkg:
  - function scan_len(W,R)
  - localparams SOFT_RST_BIT=0, WR_LSB=1
  - function rd_lsb(W)
  - typedef enum {IDLE, SHIFT, COMMIT} scan_state_e
- One sub-module, scan_len_counter: saturating CW-bit counter with clear, inc and eq_len output. It is reused by future multi-chain variants.

Test Plan:
- Config W=8,R=8 (L=17), reset, capture with chip_in=8'hA5 -> scan_data_out serial over 17 shifts = 0, 8'h00 LSB-first, 8'hA5 LSB-first.
- Shift 17 bits {data MSB..} carrying soft=0, write=8'h3C, then update -> scan_busy high 1 cycle, chip_out=8'h3C, done pulse 2 cycles after update, err=0.
- Shift 16 bits then update -> chip_out unchanged, scan_len_err=1, no done pulse. Then 17 shifts plus update -> err clears, commit occurs.
- Shift 18 bits (saturate) then update -> err=1; capture, 17 shifts, update -> success.
- Commit with bit0=1 and write=8'hFF -> chip_out=RESET_VAL, chip_soft_reset=1. Later capture reads back soft=1 and write=RESET_VAL.
- Capture, update and shift asserted together mid-shift -> capture wins, cnt=0, no commit, no error. Reset asserted during COMMIT -> chip_out=RESET_VAL, no done pulse.
